// File: rtl/replica_pkg.sv
// Shared types for the replica annealing array:
// generator commands and the iteration sequencer states.
package replica_pkg;

   typedef enum logic {
      THR = 1'b0,
      OR1 = 1'b1
   } opt_command_t;

   typedef enum logic [3:0] {
      IDLE,
      GEN_ISSUE,
      GEN_GUARD,
      GEN_WAIT,
      EVAL_ISSUE,
      EVAL_WAIT,
      EXCH_ISSUE,
      EXCH_WAIT,
      CHECK
   } sched_state_t;

   localparam int EXCH_INTERVAL_DEF = 4;

endpackage

// File: rtl/opt_sched.sv
// Iteration sequencer: fires the option generators, then the datapath,
// with an exchange pass every EXCH_INTERVAL iterations.
module opt_sched
   import replica_pkg::*;
#(
   parameter int REPLICA_NUM   = 8,
   parameter int EXCH_INTERVAL = EXCH_INTERVAL_DEF,
   parameter int ITER_W        = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic [ITER_W-1:0]      iter_num,
   input  logic                   opt_en,
   output logic                   gen_run,
   output opt_command_t           gen_com,
   input  logic [REPLICA_NUM-1:0] gen_ready,
   output logic                   dp_run,
   input  logic                   dp_done,
   output logic                   exch_run,
   output logic                   exch_odd,
   input  logic                   exch_done,
   output logic                   busy,
   output logic                   done,
   output logic [ITER_W-1:0]      iter_cnt
);

   localparam int IW = $clog2(EXCH_INTERVAL + 1);
   localparam logic [IW-1:0] INT_LAST = IW'(EXCH_INTERVAL - 1);

   sched_state_t      state;
   logic [ITER_W-1:0] iter_num_q;
   logic              opt_en_q;
   logic [IW-1:0]     int_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         gen_run    <= 1'b0;
         gen_com    <= THR;
         dp_run     <= 1'b0;
         exch_run   <= 1'b0;
         exch_odd   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         iter_cnt   <= '0;
         iter_num_q <= '0;
         opt_en_q   <= 1'b0;
         int_cnt    <= '0;
      end else if (abort) begin
         // counters and pairing phase survive an abort
         state    <= IDLE;
         gen_run  <= 1'b0;
         dp_run   <= 1'b0;
         exch_run <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         gen_run  <= 1'b0;
         dp_run   <= 1'b0;
         exch_run <= 1'b0;
         done     <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (iter_num == '0) begin
                     done <= 1'b1;
                  end else begin
                     iter_num_q <= iter_num;
                     opt_en_q   <= opt_en;
                     iter_cnt   <= '0;
                     int_cnt    <= '0;
                     gen_run    <= 1'b1;
                     gen_com    <= opt_en ? OR1 : THR;
                     busy       <= 1'b1;
                     state      <= GEN_ISSUE;
                  end
               end
            end
            GEN_ISSUE: state <= GEN_GUARD;
            // ready may still be stale from before the run pulse
            GEN_GUARD: state <= GEN_WAIT;
            GEN_WAIT: begin
               if (&gen_ready) begin
                  dp_run <= 1'b1;
                  state  <= EVAL_ISSUE;
               end
            end
            EVAL_ISSUE: state <= EVAL_WAIT;
            EVAL_WAIT: begin
               if (dp_done) begin
                  iter_cnt <= iter_cnt + ITER_W'(1);
                  if (int_cnt == INT_LAST) begin
                     int_cnt  <= '0;
                     exch_run <= 1'b1;
                     state    <= EXCH_ISSUE;
                  end else begin
                     int_cnt <= int_cnt + IW'(1);
                     state   <= CHECK;
                  end
               end
            end
            EXCH_ISSUE: state <= EXCH_WAIT;
            EXCH_WAIT: begin
               if (exch_done) begin
                  exch_odd <= ~exch_odd;
                  state    <= CHECK;
               end
            end
            CHECK: begin
               if (iter_cnt == iter_num_q) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  gen_run <= 1'b1;
                  gen_com <= opt_en_q ? OR1 : THR;
                  state   <= GEN_ISSUE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_opt_sched.sv
// Scoreboard bench for opt_sched: a run-level event model feeds a queue,
// a negedge monitor pops and compares every pulse the DUT emits.
module tb_opt_sched;
   import replica_pkg::*;

   localparam int RN = 8;
   localparam int EI = 4;
   localparam int IW = 32;

   logic          clk = 1'b0;
   logic          reset, start, abort, opt_en;
   logic [IW-1:0] iter_num;
   logic          gen_run;
   opt_command_t  gen_com;
   logic [RN-1:0] gen_ready;
   logic          dp_run, dp_done, dp_done_r, spur;
   logic          exch_run, exch_odd, exch_done;
   logic          busy, done;
   logic [IW-1:0] iter_cnt;

   assign dp_done = dp_done_r | spur;

   opt_sched #(
      .REPLICA_NUM(RN),
      .EXCH_INTERVAL(EI),
      .ITER_W(IW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .abort(abort),
      .iter_num(iter_num),
      .opt_en(opt_en),
      .gen_run(gen_run),
      .gen_com(gen_com),
      .gen_ready(gen_ready),
      .dp_run(dp_run),
      .dp_done(dp_done),
      .exch_run(exch_run),
      .exch_odd(exch_odd),
      .exch_done(exch_done),
      .busy(busy),
      .done(done),
      .iter_cnt(iter_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // responder models, driven 2 time units after each edge
   int gen_lat = 1, gen5_extra = 0, dp_lat = 1, exch_lat = 1;
   int gdrop = -1, dp_due = -10, ex_due = -10;
   int grise[RN];

   initial begin
      gen_ready = '1;
      dp_done_r = 1'b0;
      exch_done = 1'b0;
      spur      = 1'b0;
      for (int i = 0; i < RN; i++) grise[i] = -1;
   end

   always begin
      @(posedge clk);
      #2;
      for (int i = 0; i < RN; i++)
         gen_ready[i] = !(cyc >= gdrop && cyc < grise[i]);
      if (gen_run && gen_com == OR1) begin
         gdrop = cyc + 2;
         for (int i = 0; i < RN; i++)
            grise[i] = cyc + 2 + gen_lat + ((i == 5) ? gen5_extra : 0);
      end
      dp_done_r = (cyc == dp_due);
      if (dp_run) dp_due = cyc + dp_lat;
      exch_done = (cyc == ex_due);
      if (exch_run) ex_due = cyc + exch_lat;
   end

   typedef enum int {EV_GEN, EV_DP, EV_EXCH, EV_DONE} ev_k_t;
   typedef struct {
      ev_k_t k;
      int    v;
   } ev_t;

   ev_t expq[$];
   int  total = 0, bad = 0;
   int  m_odd = 0;
   int  done_cnt = 0, dp_seen = 0, gen_seen = 0;
   int  g_cyc = -1, first_rdy = -1, run_first_g = -1, done_cyc = -1;
   bit  in_exch = 0;
   int  exch_val = 0;

   task automatic chk(string name, longint act, longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic pop(ev_k_t k, int v);
      ev_t e;
      if (expq.size() == 0) begin
         chk("unexpected event", int'(k), -1);
      end else begin
         e = expq.pop_front();
         chk("event kind", int'(k), int'(e.k));
         if (e.v >= 0) chk("event value", v, e.v);
      end
   endtask

   task automatic push(ev_k_t k, int v);
      ev_t e;
      e.k = k;
      e.v = v;
      expq.push_back(e);
   endtask

   // one run from the sequencing rules, not from the state machine
   task automatic model_run(int n, bit oe);
      int itv = 0;
      if (n == 0) begin
         push(EV_DONE, -1);
         return;
      end
      for (int i = 1; i <= n; i++) begin
         push(EV_GEN, oe ? int'(OR1) : int'(THR));
         push(EV_DP, 0);
         itv++;
         if (itv == EI) begin
            itv = 0;
            push(EV_EXCH, m_odd);
            m_odd ^= 1;
         end
      end
      push(EV_DONE, n);
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (gen_run) begin
            g_cyc = cyc;
            first_rdy = -1;
            gen_seen++;
            if (run_first_g < 0) run_first_g = cyc;
            pop(EV_GEN, int'(gen_com));
         end
         if (g_cyc >= 0 && first_rdy < 0 && cyc >= g_cyc + 2 && &gen_ready)
            first_rdy = cyc;
         if (dp_run) begin
            chk("dp_run latency", cyc, first_rdy + 1);
            dp_seen++;
            pop(EV_DP, 0);
         end
         if (exch_run) begin
            in_exch = 1;
            exch_val = int'(exch_odd);
            pop(EV_EXCH, int'(exch_odd));
         end
         if (exch_done && in_exch) begin
            chk("exch_odd stable", exch_odd, exch_val);
            in_exch = 0;
         end
         if (done) begin
            done_cyc = cyc;
            done_cnt++;
            pop(EV_DONE, int'(iter_cnt));
         end
      end
   end

   task automatic do_start(int n, bit oe);
      @(posedge clk);
      #2;
      start = 1'b1;
      iter_num = n;
      opt_en = oe;
      @(posedge clk);
      #2;
      start = 1'b0;
   endtask

   task automatic run(int n, bit oe, bit lat_chk);
      int d0 = done_cnt;
      int k = 0;
      model_run(n, oe);
      run_first_g = -1;
      do_start(n, oe);
      while (done_cnt == d0 && k < 3000) begin
         @(posedge clk);
         k++;
      end
      #1;
      chk("run done count", done_cnt - d0, 1);
      chk("busy after done", busy, 0);
      chk("scoreboard drained", expq.size(), 0);
      chk("exch_odd at end", exch_odd, m_odd);
      if (lat_chk)
         chk("run latency", done_cyc - run_first_g, 6 * n + 2 * (n / EI));
   endtask

   initial begin
      int d0, k;
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      opt_en = 1'b0;
      iter_num = '0;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      @(negedge clk);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset gen_run", gen_run, 0);
      chk("reset dp_run", dp_run, 0);
      chk("reset exch_run", exch_run, 0);
      chk("reset exch_odd", exch_odd, 0);
      chk("reset iter_cnt", iter_cnt, 0);
      chk("reset gen_com", int'(gen_com), int'(THR));

      gen_lat = 2; dp_lat = 5;
      run(3, 1, 0);
      chk("iter_cnt after 3", iter_cnt, 3);
      gen_lat = 1; dp_lat = 2; exch_lat = 3;
      run(8, 1, 0);

      // generator 5 lags; a spurious dp_done lands in GEN_WAIT
      gen5_extra = 20;
      d0 = gen_seen;
      fork
         run(2, 1, 0);
         begin
            k = 0;
            while (gen_seen == d0 && k < 100) begin
               @(posedge clk);
               k++;
            end
            repeat (5) @(posedge clk);
            #2 spur = 1'b1;
            @(posedge clk);
            #2 spur = 1'b0;
         end
      join
      gen5_extra = 0;

      // zero-length run
      model_run(0, 1);
      do_start(0, 1);
      @(negedge clk);
      chk("zero run done", done, 1);
      chk("zero run busy", busy, 0);
      repeat (3) @(negedge clk);
      chk("zero run drained", expq.size(), 0);

      // start while busy is ignored
      fork
         run(6, 1, 0);
         begin
            repeat (12) @(posedge clk);
            #2 start = 1'b1;
            iter_num = 2;
            @(posedge clk);
            #2 start = 1'b0;
         end
      join

      // abort in EVAL_WAIT of iteration 2
      dp_lat = 6;
      push(EV_GEN, int'(OR1)); push(EV_DP, 0);
      push(EV_GEN, int'(OR1)); push(EV_DP, 0);
      d0 = dp_seen;
      do_start(5, 1);
      k = 0;
      while (dp_seen < d0 + 2 && k < 200) begin
         @(posedge clk);
         k++;
      end
      #2 abort = 1'b1;
      @(posedge clk);
      #2 abort = 1'b0;
      @(negedge clk);
      chk("abort busy", busy, 0);
      chk("abort iter_cnt", iter_cnt, 1);
      repeat (12) @(negedge clk);
      chk("late dp_done busy", busy, 0);
      chk("late dp_done iter_cnt", iter_cnt, 1);
      chk("abort drained", expq.size(), 0);
      dp_lat = 2;
      run(1, 1, 0);
      chk("after abort iter_cnt", iter_cnt, 1);

      // zero-wait pass-through run, exact cycle count
      dp_lat = 1; exch_lat = 1;
      run(9, 0, 1);

      for (int r = 0; r < 6; r++) begin
         gen_lat = $urandom_range(1, 3);
         gen5_extra = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) : 0;
         dp_lat = $urandom_range(1, 6);
         exch_lat = $urandom_range(1, 4);
         run($urandom_range(1, 9), 1'($urandom_range(0, 1)), 0);
         chk("random iter_cnt", iter_cnt, iter_num);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/opt_sched.md
Name: opt_sched

Overview:
- Iteration sequencer for the replica annealing loop.
- Each iteration it fires all per-replica random-option generators (K/L/metropolis/exchange draws), then starts the evaluation/update datapath.
- Every EXCH_INTERVAL iterations it triggers a replica-exchange pass, alternating even/odd pairing.
- Sits between the host control registers and the replica array; owns the iteration count and the done signalling.

Parameters:
- REPLICA_NUM, 8, number of replicas, i.e. generator instances whose ready lines are collected.
- EXCH_INTERVAL, 4, iterations between exchange passes; must be ≥1.
- ITER_W, 32, width of the iteration counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a run of iter_num iterations; ignored while busy.
- abort  in  1  level; forces return to IDLE on the next edge.
- iter_num  in  ITER_W  iterations to run; sampled on start.
- opt_en  in  1  1: generators get OR1; 0: generators get THR (pass-through iteration); sampled on start.
- gen_run  out  1  one-cycle pulse to every generator's run_i.
- gen_com  out  opt_command_t  command to the generators; valid with gen_run.
- gen_ready  in  REPLICA_NUM  per-generator ready.
- dp_run  out  1  one-cycle pulse starting the evaluation datapath.
- dp_done  in  1  single-cycle datapath completion pulse.
- exch_run  out  1  one-cycle pulse starting an exchange pass.
- exch_odd  out  1  pairing for the current exchange pass: 0 = (0,1)(2,3)…, 1 = (1,2)(3,4)…; stable from exch_run until exch_done.
- exch_done  in  1  single-cycle exchange completion pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at normal completion of a run.
- iter_cnt  out  ITER_W  completed iterations in the current or last run.

Behaviour:
- Reset values: state IDLE; gen_run, dp_run, exch_run, done, busy = 0; exch_odd = 0; iter_cnt = 0; gen_com = THR; interval counter = 0.
- Priority on every edge: reset > abort > normal transitions.
- IDLE:
  - On start with iter_num = 0: pulse done the next cycle and stay in IDLE.
  - On start with iter_num ≠ 0: latch iter_num and opt_en, clear iter_cnt and the interval counter, go to GEN_ISSUE.
- GEN_ISSUE (1 cycle): gen_run = 1; gen_com = OR1 if opt_en else THR. Next state GEN_GUARD.
- GEN_GUARD (1 cycle): gen_ready is ignored, covering generators that drop ready one edge after run. Next state GEN_WAIT.
- GEN_WAIT: wait for &gen_ready = 1, then go to EVAL_ISSUE.
  - When opt_en = 0, generators do not run, so ready stays as previously left. Ready is never deasserted in THR mode, so GEN_WAIT exits after one cycle.
- EVAL_ISSUE (1 cycle): dp_run = 1. Next state EVAL_WAIT.
- EVAL_WAIT: wait for dp_done.
  - On dp_done: iter_cnt += 1 and the interval counter += 1.
  - If the interval counter reaches EXCH_INTERVAL: clear it and go to EXCH_ISSUE.
  - Otherwise go to CHECK.
- EXCH_ISSUE (1 cycle): exch_run = 1. Next state EXCH_WAIT.
- EXCH_WAIT: on exch_done, toggle exch_odd and go to CHECK.
- CHECK (1 cycle): if iter_cnt == latched iter_num, pulse done and go to IDLE; otherwise go to GEN_ISSUE.
- Done handshakes: a dp_done or exch_done arriving in any state other than its WAIT state is ignored. Done pulses in the same cycle as the issue pulse are not accepted (one-cycle minimum latency).
- abort: next state IDLE. No done pulse. iter_cnt holds its value. exch_odd is not reset. In-flight generator, datapath or exchange activity is not cancelled; their completions are ignored.
- Counters: iter_cnt wraps at 2^ITER_W with no saturation; iter_num ≤ 2^ITER_W−1 by construction.
- Latency per iteration with zero-wait responders: 6 cycles (GEN_ISSUE, GEN_GUARD, GEN_WAIT, EVAL_ISSUE, EVAL_WAIT, CHECK), plus 2 cycles on exchange iterations.

Decomposition:
- Package replica_pkg gets:
  - sched_state_t enum (IDLE, GEN_ISSUE, GEN_GUARD, GEN_WAIT, EVAL_ISSUE, EVAL_WAIT, EXCH_ISSUE, EXCH_WAIT, CHECK);
  - default exch_interval constant;
  - reuse of the existing opt_command_t (OR1, THR).
- No sub-module. The FSM and the two counters live in one module; the ready AND-reduce is inline.

Test Plan:
- iter_num=3, opt_en=1, EXCH_INTERVAL=4, generators ready 2 cycles after run, dp_done 5 cycles after dp_run -> 3 gen_run pulses each with gen_com=OR1, 3 dp_run, 0 exch_run, done once, iter_cnt=3.
- iter_num=8, EXCH_INTERVAL=4 -> exch_run after iterations 4 and 8; exch_odd 0 for the first exchange and 1 for the second; ends at 0 after the toggle.
- Generator 5 holds ready low 20 extra cycles -> no dp_run until the cycle after gen_ready=8'hFF; the stale ready=1 in the GEN_GUARD cycle is not accepted.
- iter_num=0 start -> done one cycle later, no gen_run, busy stays 0.
- abort asserted in EVAL_WAIT of iteration 2 -> IDLE next cycle, no done, iter_cnt=1; a late dp_done is ignored; a new start with iter_num=1 completes normally.
- start pulsed while busy, and a spurious dp_done in GEN_WAIT -> no effect on state or counters; opt_en=0 run yields gen_com=THR on every gen_run.
